// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and default framing constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_rx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
   } uart_rx_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// uart_sync : two-flop synchronizer for an asynchronous single-bit input
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : oversampled UART receiver, 8N1 default; parity via UART_RX_PARITY_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int STOP_TICKS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 s_tick,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_done,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 frame_err
);

   localparam int SMAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
   localparam int SW   = $clog2(SMAX);
   localparam int NW   = $clog2(DATA_BITS);

   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
   localparam logic [NW-1:0] N_ONE  = NW'(1);

   logic rx_s;

   uart_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   uart_rx_state_t       state_q, state_d;
   logic [SW-1:0]        s_q, s_d;
   logic [NW-1:0]        n_q, n_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
   logic                 brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sh_q    <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sh_q    <= sh_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // brk_q marks a line stuck low after a framing error; a start is only
   // honoured again once the line has been seen idle high.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      sh_d    = sh_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
      brk_d   = brk_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_HALF) begin
                  if (!rx_s && !brk_q) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + S_ONE;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT) begin
                  s_d  = '0;
                  sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
                  if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_d = n_q + N_ONE;
                  end
               end else begin
                  s_d = s_q + S_ONE;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_q == S_BIT) begin
                  s_d     = '0;
                  par_d   = rx_s;
                  state_d = STOP;
               end else begin
                  s_d = s_q + S_ONE;
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP) begin
                  dout_d  = sh_q;
                  ferr_d  = ~rx_s;
                  brk_d   = ~rx_s;
                  done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_q ^ (^sh_q);
`endif
                  state_d = IDLE;
               end else begin
                  s_d = s_q + S_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dout      = dout_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx (s_tick every 4 clk)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;
   import uart_pkg::*;

   localparam int BIT_CLK = 64;   // 16 ticks x 4 clk

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic       rx     = 1'b1;
   logic       s_tick = 1'b0;
   logic [7:0] dout;
   logic       rx_done;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int errors = 0;
   int checks = 0;

   uart_rx dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .s_tick     (s_tick),
      .dout       (dout),
      .rx_done    (rx_done),
`ifdef UART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int tdiv = 0;
   always @(negedge clk) begin
      tdiv   = (tdiv + 1) % 4;
      s_tick = (tdiv == 0);
   end

   // Strobe monitor: logs every rx_done with its payload, flags wide pulses
   logic [7:0] q_dout[$];
   logic       q_ferr[$];
   logic       q_perr[$];
   int         dbl = 0;
   logic       prev_done = 1'b0;
   always @(negedge clk) begin
      if (rx_done === 1'b1) begin
         q_dout.push_back(dout);
         q_ferr.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
         q_perr.push_back(parity_err);
`else
         q_perr.push_back(1'b0);
`endif
         if (prev_done === 1'b1) dbl++;
      end
      prev_done = rx_done;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      q_dout.delete();
      q_ferr.delete();
      q_perr.delete();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v,
                             input logic par_en, input logic par_v);
      rx = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clk(BIT_CLK);
      end
      if (par_en) begin
         rx = par_v;
         wait_clk(BIT_CLK);
      end
      rx = stop_v;
      wait_clk(BIT_CLK);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx    = 1'b1;
      wait_clk(4);
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
      checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
      reset = 1'b0;
      wait_clk(BIT_CLK);
   endtask

   task automatic test_basic();
      clear_log();
      dbl = 0;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      wait_clk(8);
      checks++; if (q_dout.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d strobes want 1", q_dout.size()); end
      else begin
         checks++; if (q_dout[0] !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h want a5", q_dout[0]); end
         checks++; if (q_ferr[0] !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", q_ferr[0]); end
      end
      checks++; if (dbl !== 0) begin errors++; $display("FAIL basic_pulse_width: got %0d wide pulses want 0", dbl); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL basic_idle: got %0d want IDLE", dut.state_q); end
   endtask

   task automatic test_false_start();
      clear_log();
      rx = 1'b0;
      wait_clk(16);
      checks++; if (dut.state_q !== START) begin errors++; $display("FAIL glitch_start: got %0d want START", dut.state_q); end
      rx = 1'b1;
      wait_clk(BIT_CLK);
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_idle: got %0d want IDLE", dut.state_q); end
      wait_clk(2 * BIT_CLK);
      checks++; if (q_dout.size() !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", q_dout.size()); end
      checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout: got %h want a5", dout); end
   endtask

   task automatic test_frame_err();
      clear_log();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      wait_clk(BIT_CLK);
      checks++; if (q_dout.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d strobes want 1", q_dout.size()); end
      checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout: got %h want 3c", dout); end
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      wait_clk(8);
      checks++; if (q_dout.size() !== 2) begin errors++; $display("FAIL ferr_next_count: got %0d strobes want 2", q_dout.size()); end
      checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL ferr_next_dout: got %h want 5a", dout); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b want 0", frame_err); end
   endtask

   task automatic test_back_to_back();
      clear_log();
      dbl = 0;
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      wait_clk(8);
      checks++; if (q_dout.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d strobes want 2", q_dout.size()); end
      else begin
         checks++; if (q_dout[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", q_dout[0]); end
         checks++; if (q_dout[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", q_dout[1]); end
         checks++; if ((q_ferr[0] | q_ferr[1]) !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b%b want 00", q_ferr[0], q_ferr[1]); end
      end
      checks++; if (dbl !== 0) begin errors++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", dbl); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'h81;
      clear_log();
      rx = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         wait_clk(BIT_CLK);
      end
      rx = b[4];
      wait_clk(BIT_CLK / 2);
      checks++; if (dut.state_q !== DATA) begin errors++; $display("FAIL midrst_in_data: got %0d want DATA", dut.state_q); end
      reset = 1'b1;
      #1;
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h want 00", dout); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d want IDLE", dut.state_q); end
      wait_clk(4);
      rx = 1'b1;
      reset = 1'b0;
      wait_clk(4 * BIT_CLK);
      checks++; if (q_dout.size() !== 0) begin errors++; $display("FAIL midrst_strobe: got %0d strobes want 0", q_dout.size()); end
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      wait_clk(8);
      checks++; if (q_dout.size() !== 1) begin errors++; $display("FAIL midrst_fresh_count: got %0d strobes want 1", q_dout.size()); end
      checks++; if (dout !== 8'h81) begin errors++; $display("FAIL midrst_fresh_dout: got %h want 81", dout); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_fresh_ferr: got %b want 0", frame_err); end
   endtask

   task automatic test_break();
      clear_log();
      rx = 1'b0;
      wait_clk(20 * BIT_CLK);
      checks++; if (q_dout.size() !== 1) begin errors++; $display("FAIL break_count: got %0d strobes want 1", q_dout.size()); end
      else begin
         checks++; if (q_dout[0] !== 8'h00) begin errors++; $display("FAIL break_dout: got %h want 00", q_dout[0]); end
         checks++; if (q_ferr[0] !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", q_ferr[0]); end
      end
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
      wait_clk(8);
      checks++; if (q_dout.size() !== 2) begin errors++; $display("FAIL break_recover_count: got %0d strobes want 2", q_dout.size()); end
      checks++; if (dout !== 8'hC3) begin errors++; $display("FAIL break_recover_dout: got %h want c3", dout); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_log();
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      wait_clk(8);
      checks++; if (dout !== 8'h07) begin errors++; $display("FAIL par_good_dout: got %h want 07", dout); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good: got %b want 0", parity_err); end
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      wait_clk(8);
      checks++; if (q_dout.size() !== 2) begin errors++; $display("FAIL par_count: got %0d strobes want 2", q_dout.size()); end
      checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %b want 1", parity_err); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef UART_RX_PARITY_EN
      test_parity();
`else
      test_basic();
      test_false_start();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
      test_break();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
